// File: rtl/dcache_flush_fsm.sv
// dcache_flush_fsm: walks every set/way, writes back valid+dirty lines and invalidates each line.
// Writeback path is built only when DCACHE_FLUSH_WRITEBACK_EN is defined (otherwise write-through: invalidate only).
module dcache_flush_fsm #(
  parameter int NUM_SETS = 256,
  parameter int NUM_WAYS = 8,
  parameter int TAG_W    = 44,
  localparam int IDX_W   = (NUM_SETS > 1) ? $clog2(NUM_SETS) : 1,
  localparam int WAY_W   = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  output logic             flush_ack_o,
  output logic             busy_o,
  input  logic             miss_pending_i,
  output logic             tag_req_o,
  output logic [IDX_W-1:0] tag_idx_o,
  output logic [WAY_W-1:0] tag_way_o,
  input  logic             tag_valid_i,
  input  logic             tag_dirty_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             tag_we_o,
  output logic             wb_valid_o,
  input  logic             wb_ready_i,
  output logic [TAG_W-1:0] wb_tag_o,
  output logic [IDX_W-1:0] wb_idx_o,
  output logic [WAY_W-1:0] wb_way_o
);
  typedef enum logic [2:0] {
    IDLE,
    WAIT_IDLE,
    READ,
    CHECK,
`ifdef DCACHE_FLUSH_WRITEBACK_EN
    WB,
`endif
    INV,
    DONE,
    HOLDOFF
  } state_t;
  state_t state_q, state_d;
  logic [IDX_W-1:0] set_q;
  logic [WAY_W-1:0] way_q;
  logic set_last, way_last;
  assign set_last = set_q == IDX_W'(NUM_SETS - 1);
  assign way_last = way_q == WAY_W'(NUM_WAYS - 1);
  // State register; reset aborts any walk in progress without an ack
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) state_q <= IDLE;
    else state_q <= state_d;
  // Walk counters: cleared when a flush is accepted, advanced after each invalidate except the last line
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      set_q <= '0;
      way_q <= '0;
    end else if (state_q == IDLE && flush_i) begin
      set_q <= '0;
      way_q <= '0;
    end else if (state_q == INV && !(set_last && way_last)) begin
      way_q <= way_last ? '0 : way_q + 1'b1;
      set_q <= way_last ? set_q + 1'b1 : set_q;
    end
`ifdef DCACHE_FLUSH_WRITEBACK_EN
  logic [TAG_W-1:0] wb_tag_q;
  // Hold the dirty line's tag so the writeback payload stays stable until accepted
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) wb_tag_q <= '0;
    else if (state_q == CHECK && tag_valid_i && tag_dirty_i) wb_tag_q <= tag_i;
  assign wb_valid_o = state_q == WB;
  assign wb_tag_o   = wb_tag_q;
  assign wb_idx_o   = set_q;
  assign wb_way_o   = way_q;
`else
  logic unused_wb;
  assign unused_wb  = ^{wb_ready_i, tag_valid_i, tag_dirty_i, tag_i};
  assign wb_valid_o = 1'b0;
  assign wb_tag_o   = '0;
  assign wb_idx_o   = '0;
  assign wb_way_o   = '0;
`endif
  // Next-state: wait out refills, then READ/CHECK/(WB)/INV per line, ack, and ignore the held request once
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      state_d = flush_i ? WAIT_IDLE : IDLE;
      WAIT_IDLE: state_d = miss_pending_i ? WAIT_IDLE : READ;
      READ:      state_d = CHECK;
`ifdef DCACHE_FLUSH_WRITEBACK_EN
      CHECK:     state_d = (tag_valid_i && tag_dirty_i) ? WB : INV;
      WB:        state_d = wb_ready_i ? INV : WB;
`else
      CHECK:     state_d = INV;
`endif
      INV:       state_d = (set_last && way_last) ? DONE : READ;
      DONE:      state_d = HOLDOFF;
      HOLDOFF:   state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end
  assign busy_o      = !(state_q == IDLE || state_q == HOLDOFF);
  assign tag_req_o   = state_q == READ;
  assign tag_we_o    = state_q == INV;
  assign flush_ack_o = state_q == DONE;
  assign tag_idx_o   = set_q;
  assign tag_way_o   = way_q;
endmodule
